icache_dm: RTL and testbench

- Parametrised direct-mapped instruction cache between the datapath fetch port and the memory-controller instruction channel.
- Replaces the pass-through fetch path: hits return in the same cycle; misses run a multi-word block fill.
- Supports flush/invalidate and exposes hit and miss counters for performance runs.
- One instance per CPU.

---
 rtl/icache_dm_if.sv | 22 ++
 rtl/icache_dm.sv | 80 ++++++++
 tb/tb_icache_dm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-port, memory-channel and counter signals of the instruction cache
interface icache_dm_if #(parameter int CNTW = 32);
    logic            imemREN;
    logic [31:0]     imemaddr;
    logic            ihit;
    logic [31:0]     imemload;
    logic            flush;
    logic            iREN;
    logic [31:0]     iaddr;
    logic            iwait;
    logic [31:0]     iload;
    logic [CNTW-1:0] hitcnt;
    logic [CNTW-1:0] misscnt;
    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hitcnt, misscnt
    );
    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hitcnt, misscnt
    );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with block fill, flush and hit/miss counters
module icache_dm #(
    parameter int NSETS    = 16,
    parameter int BLKWORDS = 2,
    parameter int CNTW     = 32
) (
    input logic        CLK,
    input logic        nRST,
    icache_dm_if.slave bus
);
    localparam int WO  = $clog2(BLKWORDS);
    localparam int IX  = $clog2(NSETS);
    localparam int TW  = 30 - WO - IX;
    localparam int WOW = (WO > 0) ? WO : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state, state_n;
    logic [NSETS-1:0] valid;
    logic [TW-1:0]   tags [NSETS];
    logic [31:0]     data [NSETS][BLKWORDS];
    logic [TW-1:0]   ltag, tg;
    logic [IX-1:0]   lix, ix;
    logic [WOW-1:0]  fc, wo;
    logic [29:0]     w;
    logic [CNTW-1:0] hcnt, mcnt;
    logic            hit, start, wr, last, unused;

    assign w      = bus.imemaddr[31:2];
    assign unused = ^bus.imemaddr[1:0];
    assign wo     = (WO == 0) ? '0 : w[WOW-1:0];
    assign ix     = w[WO +: IX];
    assign tg     = w[WO+IX +: TW];

    assign bus.hitcnt  = hcnt;
    assign bus.misscnt = mcnt;

    // hit lookup, miss/fill decisions, next state and bus outputs
    always_comb begin
        hit          = state == IDLE && bus.imemREN && valid[ix] && tags[ix] == tg && !bus.flush;
        start        = state == IDLE && bus.imemREN && !hit && !bus.flush;
        wr           = state == FILL && !bus.iwait;
        last         = wr && fc == WOW'(BLKWORDS - 1);
        state_n      = start ? FILL : (state == FILL && (bus.flush || last)) ? IDLE : state;
        bus.ihit     = hit;
        bus.imemload = hit ? data[ix][wo] : '0;
        bus.iREN     = state == FILL;
        bus.iaddr    = state == FILL ? {(30'({ltag, lix}) << WO) | 30'(fc), 2'b00} : '0;
    end

    // state register
    always_ff @(posedge CLK)
        state <= !nRST ? IDLE : state_n;

    // fill bookkeeping, valid bits and saturating counters; clears beat completions
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fc    <= '0;
            hcnt  <= '0;
            mcnt  <= '0;
            valid <= '0;
        end else begin
            if (start) begin
                ltag <= tg;
                lix  <= ix;
                fc   <= '0;
            end else if (wr) fc <= fc + WOW'(1);
            if (hit && !(&hcnt)) hcnt <= hcnt + CNTW'(1);
            if (start && !(&mcnt)) mcnt <= mcnt + CNTW'(1);
            if (bus.flush) valid <= '0;
            else if (last) valid[lix] <= 1'b1;
        end
    end

    // line storage; an aborted fill may leave stale words but never a valid line
    always_ff @(posedge CLK) begin
        if (wr) data[lix][fc] <= bus.iload;
        if (last) tags[lix] <= ltag;
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed checks of the direct-mapped instruction cache
module tb_icache_dm;
    logic CLK = 0;
    logic nRST = 0;
    int   total = 0;
    int   bad = 0;
    int   wr1 = 0;

    always #5 CLK = ~CLK;

    icache_dm_if #(.CNTW(32)) b0 ();
    icache_dm_if #(.CNTW(2))  b1 ();

    icache_dm u0 (.CLK(CLK), .nRST(nRST), .bus(b0));
    icache_dm #(.BLKWORDS(4), .CNTW(2)) u1 (.CLK(CLK), .nRST(nRST), .bus(b1));

    assign b0.iload = b0.iaddr ^ 32'hC0DE_0000;
    assign b1.iload = b1.iaddr ^ 32'h5A00_0000;

    // count data writes into the 4-word-line cache
    always @(posedge CLK)
        if (b1.iREN && !b1.iwait) wr1 <= wr1 + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill0(input logic [31:0] a, input logic [31:0] d);
        b0.imemREN  = 1;
        b0.imemaddr = a;
        #1 chk("miss_ihit", b0.ihit, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("fill_iren", b0.iREN, 1);
            chk("fill_iaddr", b0.iaddr, a + 32'(4 * i));
            chk("fill_ihit", b0.ihit, 0);
            step();
        end
        chk("fill_done_ihit", b0.ihit, 1);
        chk("fill_done_load", b0.imemload, d);
        chk("fill_done_iren", b0.iREN, 0);
    endtask

    initial begin
        b0.imemREN = 0; b0.imemaddr = 0; b0.flush = 0; b0.iwait = 0;
        b1.imemREN = 0; b1.imemaddr = 0; b1.flush = 0; b1.iwait = 0;
        step();
        step();
        chk("rst_ihit", b0.ihit, 0);
        chk("rst_load", b0.imemload, 0);
        chk("rst_iren", b0.iREN, 0);
        chk("rst_iaddr", b0.iaddr, 0);
        chk("rst_hitcnt", b0.hitcnt, 0);
        chk("rst_misscnt", b0.misscnt, 0);
        nRST = 1;
        fill0(32'h40, 32'hC0DE_0040);
        chk("cold_misscnt", b0.misscnt, 1);
        chk("cold_hitcnt", b0.hitcnt, 0);
        step();
        b0.imemaddr = 32'h44;
        #1 chk("line_ihit", b0.ihit, 1);
        chk("line_load", b0.imemload, 32'hC0DE_0044);
        chk("line_iren", b0.iREN, 0);
        step();
        chk("line_hitcnt", b0.hitcnt, 2);
        fill0(32'h140, 32'hC0DE_0140);
        step();
        fill0(32'h40, 32'hC0DE_0040);
        chk("conflict_misscnt", b0.misscnt, 3);
        b0.flush = 1;
        #1 chk("flush_gate_ihit", b0.ihit, 0);
        chk("flush_gate_load", b0.imemload, 0);
        step();
        b0.flush = 0;
        #1 chk("flush_idle_inval", b0.ihit, 0);
        b0.imemREN = 0;
        step();
        b0.imemREN  = 1;
        b0.imemaddr = 32'h80;
        step();
        chk("abort_iaddr0", b0.iaddr, 32'h80);
        step();
        b0.flush = 1;
        #1 chk("abort_iaddr1", b0.iaddr, 32'h84);
        step();
        b0.flush = 0;
        #1 chk("abort_iren", b0.iREN, 0);
        chk("abort_ihit", b0.ihit, 0);
        fill0(32'h80, 32'hC0DE_0080);
        chk("abort_misscnt", b0.misscnt, 5);
        step();
        b0.imemaddr = 32'h200;
        step();
        b0.imemREN  = 0;
        b0.imemaddr = 32'h40;
        #1 chk("move_iaddr0", b0.iaddr, 32'h200);
        step();
        chk("move_iaddr1", b0.iaddr, 32'h204);
        step();
        chk("move_iren", b0.iREN, 0);
        b0.imemREN  = 1;
        b0.imemaddr = 32'h200;
        #1 chk("move_ihit", b0.ihit, 1);
        chk("move_load", b0.imemload, 32'hC0DE_0200);
        step();
        b0.imemaddr = 32'h140;
        step();
        step();
        nRST = 0;
        step();
        nRST = 1;
        b0.imemREN = 0;
        #1 chk("rst2_ihit", b0.ihit, 0);
        chk("rst2_load", b0.imemload, 0);
        chk("rst2_iren", b0.iREN, 0);
        chk("rst2_iaddr", b0.iaddr, 0);
        chk("rst2_hitcnt", b0.hitcnt, 0);
        chk("rst2_misscnt", b0.misscnt, 0);
        fill0(32'h200, 32'hC0DE_0200);
        chk("rst2_refill_misscnt", b0.misscnt, 1);
        step();
        b0.imemREN = 0;
        b1.iwait    = 1;
        b1.imemREN  = 1;
        b1.imemaddr = 32'h100;
        #1 chk("stall_miss_ihit", b1.ihit, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            repeat (3) begin
                chk("stall_iaddr", b1.iaddr, 32'h100 + 32'(4 * k));
                chk("stall_iren", b1.iREN, 1);
                chk("stall_ihit", b1.ihit, 0);
                step();
            end
            b1.iwait = 0;
            chk("stall_word_iaddr", b1.iaddr, 32'h100 + 32'(4 * k));
            step();
            b1.iwait = 1;
        end
        chk("stall_ihit_after", b1.ihit, 1);
        chk("stall_load0", b1.imemload, 32'h5A00_0100);
        chk("stall_writes", 64'(wr1), 4);
        step();
        for (int k = 1; k < 4; k++) begin
            b1.imemaddr = 32'h100 + 32'(4 * k);
            #1 chk("stall_load_k", b1.imemload, 32'h5A00_0100 + 32'(4 * k));
            step();
        end
        chk("sat_hitcnt", b1.hitcnt, 3);
        chk("stall_misscnt", b1.misscnt, 1);
        b1.imemREN = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
